// File: rtl/mac_pkg.sv
// Shared definitions for the mac_acc_16 multiply-accumulate stage: state
// encoding, default widths and signed saturation limits.
package mac_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } mac_state_t;

    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;
    localparam int PROD_W    = 32;

    // Limits are built at 64 bits and narrowed by the user; valid for w <= 64.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_acc_sat.sv
// ACC_W-wide accumulate of a sign-extended 32-bit product with signed
// overflow detect; clamps to the signed limits when MAC_ACC_SAT_EN is defined.
module mac_acc_sat
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] raw_sum;

`ifdef MAC_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    // Both addends share a sign on overflow, so that sign picks the rail.
    function automatic logic signed [ACC_W-1:0] clamp(
        input logic signed [ACC_W-1:0] value,
        input logic                    over,
        input logic                    neg
    );
        if (!over)
            return value;
        return neg ? SAT_MIN : SAT_MAX;
    endfunction
`endif

    assign prod_ext = ACC_W'(prod);
    assign raw_sum  = acc + prod_ext;
    assign ovf      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (raw_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef MAC_ACC_SAT_EN
    assign sum = clamp(raw_sum, ovf, acc[ACC_W-1]);
`else
    assign sum = raw_sum;
`endif

endmodule

// File: rtl/mul_tc_16_16.sv
// Combinational 16x16 two's-complement multiplier with a full 32-bit product.
module mul_tc_16_16 (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] product
);

    assign product = a * b;

endmodule

// File: rtl/mac_acc_16.sv
// Two-stage multiply-accumulate over valid/ready streams: one result per
// group closed by in_last. Optional clamping build macro: MAC_ACC_SAT_EN.
module mac_acc_16
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_a,
    input  logic signed [15:0]      in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_ovf
);

    logic signed [PROD_W-1:0] prod_p0;
    logic                     hs_p0;
    logic signed [PROD_W-1:0] prod_p1;
    logic                     vld_p1;
    logic                     last_p1;
    logic                     adv_p1;

    mac_state_t               state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  sum_p1;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_base;
    logic [CNT_W-1:0]         cnt_nxt;
    logic                     ovf_q;
    logic                     ovf_base;
    logic                     ovf_new;

    mul_tc_16_16 u_mul (
        .a       (in_a),
        .b       (in_b),
        .product (prod_p0)
    );

    // A held last term may only retire once the output register is free.
    assign adv_p1   = vld_p1 & (~last_p1 | ~out_valid | out_ready);
    assign in_ready = rst_n & (~vld_p1 | adv_p1);
    assign hs_p0    = in_valid & in_ready;

    assign acc_base = (state_q == ST_IDLE) ? '0 : acc_q;
    assign cnt_base = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign ovf_base = (state_q == ST_IDLE) ? 1'b0 : ovf_q;
    assign cnt_nxt  = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;

    mac_acc_sat #(.ACC_W(ACC_W)) u_sat (
        .acc  (acc_base),
        .prod (prod_p1),
        .sum  (sum_p1),
        .ovf  (ovf_new)
    );

    // ---- stage 0 -> stage 1: product register ----
    always_ff @(posedge clk) begin
        if (hs_p0)
            prod_p1 <= prod_p0;
    end

    // ---- stage 1 -> stage 2: accumulate and result register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (hs_p0) begin
                vld_p1  <= 1'b1;
                last_p1 <= in_last;
            end else if (adv_p1) begin
                vld_p1  <= 1'b0;
            end

            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (adv_p1) begin
                if (last_p1) begin
                    out_acc   <= sum_p1;
                    out_cnt   <= cnt_nxt;
                    out_ovf   <= ovf_base | ovf_new;
                    out_valid <= 1'b1;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                    state_q   <= ST_IDLE;
                end else begin
                    acc_q     <= sum_p1;
                    cnt_q     <= cnt_nxt;
                    ovf_q     <= ovf_base | ovf_new;
                    state_q   <= ST_ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_16.sv
// Directed bench for mac_acc_16: a 40-bit/8-bit instance and a 32-bit/2-bit
// instance driven from the same stream; honours MAC_ACC_SAT_EN for expectations.
module tb_mac_acc_16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_a;
    logic signed [15:0] in_b;
    logic               in_last;
    logic               out_ready;

    logic               in_ready;
    logic               out_valid;
    logic [39:0]        out_acc;
    logic [7:0]         out_cnt;
    logic               out_ovf;

    logic               s_in_ready;
    logic               s_out_valid;
    logic [31:0]        s_out_acc;
    logic [1:0]         s_out_cnt;
    logic               s_out_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_acc_16 #(.ACC_W(40), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
    );

    mac_acc_16 #(.ACC_W(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_acc(s_out_acc), .out_cnt(s_out_cnt), .out_ovf(s_out_ovf)
    );

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic               last;
        logic [39:0]        acc;
        logic [7:0]         cnt;
        logic               ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b, input logic last);
        int n;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last pair's handshake; out_ready is expected high.
    task automatic wait_out(input string nm, input logic [39:0] acc, input logic [7:0] cnt,
                            input logic ovf, input bit s_en, input logic [31:0] s_acc,
                            input logic [1:0] s_cnt, input logic s_ovf);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_acc"}, out_acc, acc);
        chk({nm, "_cnt"}, out_cnt, cnt);
        chk({nm, "_ovf"}, out_ovf, ovf);
        if (s_en) begin
            chk({nm, "_s_valid"}, s_out_valid, 1);
            chk({nm, "_s_acc"}, s_out_acc, s_acc);
            chk({nm, "_s_cnt"}, s_out_cnt, s_cnt);
            chk({nm, "_s_ovf"}, s_out_ovf, s_ovf);
        end
        @(posedge clk);
        #1;
        chk({nm, "_drained"}, out_valid, 0);
    endtask

    initial begin
        logic [31:0] exp_ovf_acc;
`ifdef MAC_ACC_SAT_EN
        exp_ovf_acc = 32'h7FFF_FFFF;
`else
        exp_ovf_acc = 32'h8000_0000;
`endif

        vecs[0] = '{16'sd3,      16'sd4,      1'b0, 40'd0,              8'd0, 1'b0};
        vecs[1] = '{-16'sd5,     16'sd6,      1'b1, 40'(-18),           8'd2, 1'b0};
        vecs[2] = '{16'sh8000,   16'sh8000,   1'b1, 40'(1073741824),    8'd1, 1'b0};
        vecs[3] = '{16'sh8000,   16'sd32767,  1'b1, 40'(-1073709056),   8'd1, 1'b0};
        vecs[4] = '{16'sd100,    -16'sd200,   1'b0, 40'd0,              8'd0, 1'b0};
        vecs[5] = '{16'sd7,      16'sd7,      1'b0, 40'd0,              8'd0, 1'b0};
        vecs[6] = '{16'sd0,      16'sd5,      1'b1, 40'(-19951),        8'd3, 1'b0};
        vecs[7] = '{16'sd32767,  16'sd32767,  1'b1, 40'(1073676289),    8'd1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].last);
            if (vecs[i].last)
                wait_out($sformatf("vec%0d", i), vecs[i].acc, vecs[i].cnt, vecs[i].ovf,
                         1'b0, 32'd0, 2'd0, 1'b0);
        end

        // Back-to-back groups against a stalled output.
        out_ready = 1'b0;
        send(16'sd1, 16'sd2, 1'b1);
        send(16'sd3, 16'sd3, 1'b0);
        send(16'sd4, 16'sd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i), out_valid, 1);
            chk($sformatf("stall%0d_acc", i), out_acc, 40'd2);
            chk($sformatf("stall%0d_cnt", i), out_cnt, 8'd1);
            chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_reload_valid", out_valid, 1);
        chk("stall_reload_acc", out_acc, 40'd25);
        chk("stall_reload_cnt", out_cnt, 8'd2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_no_dup%0d", i), out_valid, 0);
            @(posedge clk);
            #1;
        end

        // Overflow on the 32-bit instance; the 40-bit one holds 2^31 cleanly.
        send(16'sh8000, 16'sh8000, 1'b0);
        send(16'sh8000, 16'sh8000, 1'b1);
        wait_out("ovf", 40'h00_8000_0000, 8'd2, 1'b0, 1'b1, exp_ovf_acc, 2'd2, 1'b1);

        // Reset in the middle of a group discards it.
        for (int i = 0; i < 3; i++)
            send(16'sd10, 16'sd10, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_no_stale%0d", i), out_valid, 0);
            @(posedge clk);
            #1;
        end
        send(16'sd2, 16'sd2, 1'b1);
        wait_out("midrst", 40'd4, 8'd1, 1'b0, 1'b1, 32'd4, 2'd1, 1'b0);

        // Count saturation on the 2-bit counter.
        for (int i = 0; i < 5; i++)
            send(16'sd1, 16'sd1, (i == 4));
        wait_out("cntsat", 40'd5, 8'd5, 1'b0, 1'b1, 32'd5, 2'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_acc_16.md
Name: mac_acc_16

Overview:
- Sequential multiply-accumulate stage wrapped around the combinational 16x16 two's-complement multiplier `mul_tc_16_16`; it feeds that multiplier and consumes its product.
- Accepts operand pairs over a valid/ready stream, registers each product, and sums the products of a group into a signed accumulator.
- Emits one result per group, with the group end marked by `in_last`, over a valid/ready output stream.
- Sits between the operand fetch logic and the writeback stage of the DSP datapath.

Parameters:
- ACC_W, 40, accumulator and result width in bits. Must be at least 32; the product is sign-extended to this width.
- CNT_W, 8, width of the per-group term counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept an operand pair
- in_a  in  16  operand a, two's complement
- in_b  in  16  operand b, two's complement
- in_last  in  1  this pair closes the current group
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_acc  out  ACC_W  accumulated group sum, two's complement
- out_cnt  out  CNT_W  number of terms in the group, saturating at 2^CNT_W-1
- out_ovf  out  1  signed overflow occurred somewhere in the group (sticky within the group)

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following: in_ready=0 during reset, out_valid=0, out_acc=0, out_cnt=0, out_ovf=0, accumulator=0, term count=0, stage-1 valid=0, state=ST_IDLE. Any in-flight group is discarded and no partial result is emitted. in_ready is 1 in the first cycle after reset is released.
- Stage 1 (S1):
  - On an input handshake (in_valid & in_ready), register `mul_tc_16_16(in_a, in_b)` into p_reg[31:0], set s1_last=in_last and s1_valid=1.
- Stage 2 (S2):
  - S2 consumes S1 when s1_adv, where s1_adv = s1_valid & (~s1_last | ~out_valid | out_ready).
  - sum = acc + sign_extend(p_reg, ACC_W).
  - Overflow is detected when acc and the extended product have equal sign bits and the sign of sum differs. It ORs into the group's sticky ovf bit.
- in_ready = ~s1_valid | s1_adv. This gives full throughput of one pair per cycle while the output path is not stalled.
- Result:
  - When s1_adv & s1_last: out_acc <= sum, out_cnt <= cnt+1 (saturating), out_ovf <= ovf_sticky | new_ovf, out_valid <= 1.
  - In the same cycle, acc, cnt and ovf_sticky are cleared.
  - The next group's first product may enter S1 in that same cycle.
- out_valid stays high and out_* hold stable until out_ready. If a new last completes in the same cycle out_ready=1, the output register reloads and out_valid stays 1 with no bubble.
- State machine, tracked on S2 consumption:
  - ST_IDLE: no terms accumulated.
  - ST_IDLE -> ST_ACC on a non-last consume.
  - ST_IDLE -> ST_IDLE on a last consume (single-term group; result = that product).
  - ST_ACC -> ST_IDLE on a last consume.
  - ST_ACC -> ST_ACC on a non-last consume.
  - Output holding is independent of the state.
- Latency: 2 cycles from the handshake of a last pair to out_valid=1, when unstalled.
- Wrap: without saturation, acc wraps modulo 2^ACC_W; only out_ovf reports it. cnt saturates and does not wrap.
- in_valid low between pairs of a group is allowed and does not affect the accumulator.

Optional Feature:
- Macro MAC_ACC_SAT_EN.
- Defined:
  - On overflow, acc clamps to the signed maximum 2^(ACC_W-1)-1 or the signed minimum -2^(ACC_W-1), according to the direction of the overflow.
  - Further terms continue to accumulate from the clamped value.
  - out_ovf behaves as before.
- Undefined: two's-complement wrap, as described in Behaviour.

Decomposition:
- Shared package `mac_pkg`:
  - state encoding ST_IDLE=1'b0, ST_ACC=1'b1
  - default widths ACC_W=40, CNT_W=8
  - saturation limit constants as functions of ACC_W
- Sub-module: `mac_acc_sat`, combinational, ACC_W-wide add with overflow detect and optional clamp. `mul_tc_16_16` is instantiated unchanged.

Test Plan:
- Two-term group, no stalls: (3,4), then (-5,6,last) -> out_acc=-18, out_cnt=2, out_ovf=0, out_valid exactly 2 cycles after the last handshake.
- Single-term extreme: (-32768,-32768,last) -> out_acc=1073741824, out_cnt=1. Then (-32768,32767,last) -> out_acc=-1073709056.
- Back-to-back groups with out_ready=0 for 5 cycles:
  - first result holds stable and in_ready drops once the second group's last pair reaches S1
  - with out_ready restored, the second result is delivered with no lost or duplicated group
- Overflow with ACC_W=32: two terms (-32768,-32768), (-32768,-32768,last) -> out_ovf=1. out_acc=0x80000000 (wrap), or 0x7FFFFFFF with MAC_ACC_SAT_EN.
- Reset mid-group: after 3 non-last pairs, hold rst_n=0 for one cycle, then send (2,2,last) -> out_acc=4, out_cnt=1, and no stale output appears.
- Count saturation with CNT_W=2: 5-term group of (1,1) -> out_acc=5, out_cnt=3.
